// File: rtl/master_nios_irq_pkg.sv
// Shared constants for the master Nios II interrupt aggregator.
//   - register word addresses on the 16-bit slave bus
//   - bit position of the valid flag in the ACTIVE register
//   - maximum supported line count and a helper that builds the
//     "implemented lines" bit mask for a given line count
package master_nios_irq_pkg;

   localparam int IRQ_MAX = 16;

   localparam logic [2:0] IRQ_ADDR_STATUS  = 3'd0;
   localparam logic [2:0] IRQ_ADDR_PENDING = 3'd1;
   localparam logic [2:0] IRQ_ADDR_MASK    = 3'd2;
   localparam logic [2:0] IRQ_ADDR_EDGE    = 3'd3;
   localparam logic [2:0] IRQ_ADDR_ACTIVE  = 3'd4;
   localparam logic [2:0] IRQ_ADDR_FORCE   = 3'd5;

   localparam int ACTIVE_VALID_BIT = 15;

   // Ones in bit positions [n-1:0]; clamps n to the supported range so
   // bits of unimplemented lines always stay 0.
   function automatic logic [IRQ_MAX-1:0] line_mask(input int n);
      int k;
      k = (n > IRQ_MAX) ? IRQ_MAX : ((n < 0) ? 0 : n);
      return IRQ_MAX'((33'd1 << k) - 33'd1);
   endfunction

endpackage

// File: rtl/master_nios_irq_prio_enc.sv
// Lowest-index priority encoder, 16 requests to a 4-bit id.
// Ports:
//   req   [15:0] in  : request vector (pending & masked)
//   id    [3:0]  out : index of the lowest set request, 0 when none
//   valid        out : at least one request set
module master_nios_irq_prio_enc (
   input  logic [15:0] req,
   output logic [3:0]  id,
   output logic        valid
);

   // Scan from the top down so the lowest set index is the last write.
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (req[i]) begin
            id    = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/master_nios_irq_aggregator.sv
// Interrupt aggregator for the master Nios II SoC. Collects NUM_IRQ level
// lines, latches them per line as level- or edge-sensitive, masks them and
// drives one registered irq_out. ACTIVE reports the lowest pending, enabled
// source.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   irq_in [NUM_IRQ-1:0]  : interrupt lines, synchronous to clk
//   chipselect, write_n   : slave select, active-low write strobe
//   address [2:0]         : word address
//   writedata [15:0]      : write data
//   readdata [15:0]       : registered read data (1-cycle latency)
//   irq_out               : registered combined interrupt
module master_nios_irq_aggregator
   import master_nios_irq_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [2:0]         address,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   output logic               irq_out
);

   localparam logic [15:0] LINES = line_mask(NUM_IRQ);

   logic [15:0] latch, prev, mask, edge_mode;
   logic [15:0] irq_ext, ev, pend, hit;
   logic [15:0] set_vec, clr_vec, latch_nxt, rd_nxt;
   logic        wr_en;
   logic [3:0]  act_id;
   logic        act_valid;

   always_comb begin
      irq_ext              = '0;
      irq_ext[NUM_IRQ-1:0] = irq_in;
   end

   assign wr_en = chipselect & ~write_n;

   // prev tracks the input in every mode, so switching a line into edge
   // mode never sees a stale low and fakes a rising edge.
   assign ev   = irq_ext & ~prev;
   assign pend = latch | (irq_ext & ~edge_mode);
   assign hit  = pend & mask;

   master_nios_irq_prio_enc u_prio_enc (
      .req   (hit),
      .id    (act_id),
      .valid (act_valid)
   );

   // Set dominates clear so an edge arriving during a W1C is not lost.
   always_comb begin
      set_vec = ev & edge_mode;
      clr_vec = '0;
      if (wr_en && address == IRQ_ADDR_FORCE)   set_vec = set_vec | writedata;
      if (wr_en && address == IRQ_ADDR_PENDING) clr_vec = writedata;
      latch_nxt = ((latch & ~clr_vec) | set_vec) & LINES;
   end

   always_comb begin
      rd_nxt = '0;
      case (address)
         IRQ_ADDR_STATUS:  rd_nxt = irq_ext;
         IRQ_ADDR_PENDING: rd_nxt = pend;
         IRQ_ADDR_MASK:    rd_nxt = mask;
         IRQ_ADDR_EDGE:    rd_nxt = edge_mode;
         IRQ_ADDR_ACTIVE: begin
            rd_nxt[ACTIVE_VALID_BIT] = act_valid;
            rd_nxt[3:0]              = act_id;
         end
         default:          rd_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         latch     <= '0;
         prev      <= '0;
         mask      <= '0;
         edge_mode <= '0;
         readdata  <= '0;
         irq_out   <= 1'b0;
      end else begin
         latch    <= latch_nxt;
         prev     <= irq_ext;
         readdata <= rd_nxt;
         irq_out  <= |hit;
         if (wr_en && address == IRQ_ADDR_MASK) mask      <= writedata & LINES;
         if (wr_en && address == IRQ_ADDR_EDGE) edge_mode <= writedata & LINES;
      end
   end

endmodule
